// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline stage register
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_OCC_W = 2;

  // State encoding is chosen so the state value is the entry count.
  function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_e s);
    return PIPE_OCC_W'(s);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - single payload register with valid bit, load/unload and clear
module pipe_entry #(
  parameter int WIDTH      = 32,
  parameter int CLEAR_DATA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Clear beats load, so a payload arriving alongside a flush is dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      if (CLEAR_DATA != 0) begin
        data <= '0;
      end
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline register with optional skid entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [PIPE_OCC_W-1:0] occupancy
);

  logic             in_xfer;
  logic             out_xfer;
  logic             main_load;
  logic             main_unload;
  logic [WIDTH-1:0] main_din;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  pipe_entry #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (main_load),
    .unload    (main_unload),
    .load_data (main_din),
    .valid     (out_valid),
    .data      (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_e      state;
      logic             in_ready_q;
      logic             skid_load;
      logic             skid_unload;
      logic             skid_valid;
      logic [WIDTH-1:0] skid_data;

      pipe_entry #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (skid_load),
        .unload    (skid_unload),
        .load_data (in_data),
        .valid     (skid_valid),
        .data      (skid_data)
      );

      always_comb begin
        main_load   = 1'b0;
        main_unload = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        main_din    = skid_valid ? skid_data : in_data;
        case (state)
          PS_EMPTY: begin
            main_load = in_xfer;
          end
          PS_ONE: begin
            main_load   = in_xfer & out_xfer;
            main_unload = out_xfer & ~in_xfer;
            skid_load   = in_xfer & ~out_xfer;
          end
          PS_TWO: begin
            // in_ready is low here, so only the skid can refill main.
            main_load   = out_xfer;
            skid_unload = out_xfer;
          end
          default: begin
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          state      <= PS_EMPTY;
          in_ready_q <= 1'b1;
        end else begin
          case (state)
            PS_EMPTY: begin
              if (in_xfer) begin
                state <= PS_ONE;
              end
            end
            PS_ONE: begin
              if (in_xfer && !out_xfer) begin
                state      <= PS_TWO;
                in_ready_q <= 1'b0;
              end else if (out_xfer && !in_xfer) begin
                state <= PS_EMPTY;
              end
            end
            PS_TWO: begin
              if (out_xfer) begin
                state      <= PS_ONE;
                in_ready_q <= 1'b1;
              end
            end
            default: begin
              state      <= PS_EMPTY;
              in_ready_q <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready  = in_ready_q;
      assign occupancy = occ_of(state);
    end else begin : g_single
      assign in_ready    = ~out_valid | out_ready;
      assign main_load   = in_xfer;
      assign main_unload = out_xfer & ~in_xfer;
      assign main_din    = in_data;
      assign occupancy   = {1'b0, out_valid};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench running SKID=0 and SKID=1 instances side by side
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] out_data  [2];
  logic [1:0]  occupancy [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CLEAR_DATA(1)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready[0]),
    .out_valid (out_valid[0]),
    .out_data  (out_data[0]),
    .out_ready (out_ready),
    .occupancy (occupancy[0])
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CLEAR_DATA(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready[1]),
    .out_valid (out_valid[1]),
    .out_data  (out_data[1]),
    .out_ready (out_ready),
    .occupancy (occupancy[1])
  );

  // Reference model: one FIFO of accepted payloads per instance.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          tests = 0;
  int          fails = 0;
  bit          armed = 1'b0;
  bit          cleared   [2];
  bit          prev_stall[2];
  logic [31:0] prev_data [2];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int k, input logic [31:0] d);
    if (k == 0) q0.push_back(d);
    else q1.push_back(d);
  endfunction

  function automatic logic [31:0] qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s skid=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < 2; k++) begin
      chk("occupancy", k, 32'(occupancy[k]), 32'(qsize(k)));
      chk("out_valid", k, 32'(out_valid[k]), 32'(qsize(k) != 0));
      if (cleared[k]) chk("cleared_data", k, out_data[k], 32'h0);
    end
    chk("in_ready_reg", 1, 32'(in_ready[1]), 32'(qsize(1) < 2));
    chk("occ_le_1", 0, 32'(occupancy[0] <= 2'd1), 32'd1);
  endtask

  task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit fl, input bit r);
    @(negedge clk);
    #1;
    if (armed) check_state();
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    if (armed) begin
      chk("in_ready_comb", 0, 32'(in_ready[0]), 32'(!out_valid[0] || ordy));
      if (occupancy[1] == 2'd2) chk("no_in_when_two", 1, 32'(iv && in_ready[1]), 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      if (armed && iv && in_ready[k] && !fl && !r) begin
        qpush(k, d);
        cleared[k] = 1'b0;
      end
    end
    @(posedge clk);
    if (fl || r) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        cleared[k]    = 1'b1;
        prev_stall[k] = 1'b0;
      end
    end
    if (r) armed = 1'b1;
  endtask

  // Monitor: samples just before each rising edge and retires output transfers.
  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_stall[k] = 1'b0;
      prev_data[k]  = 32'h0;
      cleared[k]    = 1'b0;
    end
    forever begin
      @(negedge clk);
      #4;
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          if (prev_stall[k] && out_valid[k]) chk("stall_stable", k, out_data[k], prev_data[k]);
          if (out_valid[k] && out_ready) begin
            if (qsize(k) == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_output skid=%0d actual=%h required=none", k, out_data[k]);
            end else begin
              chk("out_data_order", k, out_data[k], qpop(k));
            end
          end
          prev_stall[k] = out_valid[k] && !out_ready;
          prev_data[k]  = out_data[k];
        end
      end
    end
  end

  initial begin
    step(0, 32'h0, 0, 0, 1);

    // Streaming at full rate.
    step(1, 32'hDEAD0001, 1, 0, 0);
    step(1, 32'hDEAD0002, 1, 0, 0);
    step(1, 32'hDEAD0003, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // Stall fills the skid entry, then drains in order.
    step(1, 32'h000000A1, 0, 0, 0);
    step(1, 32'h000000A2, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // Flush while full, with a concurrent input that must be dropped.
    step(1, 32'h000000A1, 0, 0, 0);
    step(1, 32'h000000A2, 0, 0, 0);
    step(1, 32'h000000FF, 0, 1, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // Reset together with flush while full.
    step(1, 32'h000000B1, 0, 0, 0);
    step(1, 32'h000000B2, 0, 0, 0);
    step(1, 32'h000000B3, 0, 1, 1);
    step(0, 32'h0, 0, 0, 0);

    // Single-entry stall then back-to-back capture of 0x55.
    step(1, 32'h00000044, 0, 0, 0);
    step(1, 32'h00000055, 0, 0, 0);
    step(1, 32'h00000055, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 63) == 0, $urandom_range(0, 511) == 0);
    end

    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);
    chk("drained", 0, 32'(qsize(0)), 32'd0);
    chk("drained", 1, 32'(qsize(1)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
